// File: rtl/acc_recv_ctrl_if.sv
// Upstream handshake/bus bundle for acc_recv_ctrl.
// master = upstream sender (drives enable, valid, address, data; watches done)
// slave  = acc_recv_ctrl receive side
interface acc_recv_ctrl_if #(
  parameter int ACC_ADDR_W = 4,
  parameter int DATA_W     = 16
);
  logic                  en_in;
  logic                  acc_valid_in;
  logic [ACC_ADDR_W-1:0] acc_addr_in;
  logic [DATA_W-1:0]     acc_data_in;
  logic                  acc_done_out;

  modport master (
    output en_in, acc_valid_in, acc_addr_in, acc_data_in,
    input  acc_done_out
  );

  modport slave (
    input  en_in, acc_valid_in, acc_addr_in, acc_data_in,
    output acc_done_out
  );
endinterface

// File: rtl/acc_recv_ctrl.sv
// Accumulator receive controller: arms with a one-cycle done pulse, takes
// ACC_SIZE words into the local accumulator through a registered write
// port, counts committed writes in idx and parks in FULL until the local
// send side drains the buffer (idx_init).
//
// Optional build macro ACC_RECV_ADDR_CHK_EN: check incoming addresses
// against the expected pointer, drop mismatches and raise a sticky err_out;
// valid words outside RECV also raise err_out. Without the macro the
// address is ignored and err_out is tied low.
//
// state | meaning
// IDLE  | waiting for en_in
// ARM   | acc_done_out high for this one cycle, pointer cleared
// RECV  | accepting words until ACC_SIZE writes have committed
// FULL  | buffer complete, waiting for idx_init
module acc_recv_ctrl #(
  parameter int ACC_ADDR_W = 4,
  parameter int ACC_SIZE   = 9,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = $clog2(ACC_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  acc_recv_ctrl_if.slave        bus,
  input  logic                  idx_init,
  output logic                  wr_en,
  output logic [ACC_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [IDX_W-1:0]      idx,
  output logic                  err_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [ACC_ADDR_W-1:0] PTR_LAST = ACC_ADDR_W'(ACC_SIZE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(ACC_SIZE - 1);

  logic [1:0]            state_q, state_d;
  logic [ACC_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  last_q, last_d;   // final word of this transfer already taken
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_en_q, wr_en_d;
  logic [ACC_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;

  logic in_recv;
  logic addr_ok;
  logic accept;

  // Accept decision for the word presented this cycle
  always_comb begin
    in_recv = (state_q == S_RECV);
`ifdef ACC_RECV_ADDR_CHK_EN
    addr_ok = (bus.acc_addr_in == ptr_q);
`else
    addr_ok = 1'b1;
`endif
    accept  = in_recv && bus.acc_valid_in && !last_q && addr_ok;
  end

  // Next-state, pointer, write-port and commit-count logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    idx_d     = idx_q;
    wr_en_d   = accept;
    wr_addr_d = accept ? ptr_q : wr_addr_q;
    wr_data_d = accept ? bus.acc_data_in : wr_data_q;

    // idx trails the write strobe so it only counts writes that happened
    if (wr_en_q) idx_d = idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.en_in) state_d = S_ARM;
      end
      S_ARM: begin
        ptr_d   = '0;
        last_d  = 1'b0;
        state_d = S_RECV;
      end
      S_RECV: begin
        if (accept) begin
          if (ptr_q == PTR_LAST) begin
            ptr_d  = '0;
            last_d = 1'b1;
          end else begin
            ptr_d = ptr_q + ACC_ADDR_W'(1);
          end
        end
        if (wr_en_q && (idx_q == IDX_LAST)) state_d = S_FULL;
      end
      S_FULL: begin
        if (idx_init) begin
          idx_d   = '0;
          state_d = bus.en_in ? S_ARM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered state, async active-high reset abandons any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef ACC_RECV_ADDR_CHK_EN
  logic err_q, err_d;

  // Sticky error: out-of-order address in RECV, or any valid outside RECV
  always_comb begin
    err_d = err_q;
    if (bus.acc_valid_in && !in_recv) err_d = 1'b1;
    if (in_recv && bus.acc_valid_in && !last_q && !addr_ok) err_d = 1'b1;
  end

  // Error flag clears only on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

  assign bus.acc_done_out = (state_q == S_ARM);
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign idx              = idx_q;

endmodule

// File: tb/tb_acc_recv_ctrl.sv
// Bench for acc_recv_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a transfer-level reference model.
module tb_acc_recv_ctrl;

  localparam int AW = 4;
  localparam int N  = 9;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          idx_init;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    idx;
  logic          err_out;

  acc_recv_ctrl_if #(.ACC_ADDR_W(AW), .DATA_W(DW)) bus ();

  acc_recv_ctrl #(.ACC_ADDR_W(AW), .ACC_SIZE(N), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .idx_init (idx_init),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .idx      (idx),
    .err_out  (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef ACC_RECV_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic v, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic ii);
    bus.en_in        = en;
    bus.acc_valid_in = v;
    bus.acc_addr_in  = a;
    bus.acc_data_in  = d;
    idx_init         = ii;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " done"},    32'(bus.acc_done_out), 0);
    chk({tag, " wr_en"},   32'(wr_en), 0);
    chk({tag, " wr_addr"}, 32'(wr_addr), 0);
    chk({tag, " wr_data"}, 32'(wr_data), 0);
    chk({tag, " idx"},     32'(idx), 0);
    chk({tag, " err"},     32'(err_out), 0);
  endtask

  typedef struct {
    logic          en;
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ii;
    logic          e_done;
    logic          e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            e_idx;
    logic          e_err;
  } vec_t;

  vec_t vt[15];

  // reference model state (transfer level)
  int          m_phase;   // 0 waiting, 1 done pulse, 2 taking words, 3 full
  int          m_taken;
  int          m_commit;
  bit          m_pend;
  int          m_paddr;
  int          m_pdata;
  bit          m_err;

  task automatic model_reset();
    m_phase = 0; m_taken = 0; m_commit = 0; m_pend = 0;
    m_paddr = 0; m_pdata = 0; m_err = 0;
  endtask

  task automatic model_clock(input bit en, input bit v, input int a, input int d, input bit ii);
    bit np;
    int old_phase;
    np = 0;
    old_phase = m_phase;
    if (CHK && v && old_phase != 2) m_err = 1;
    case (old_phase)
      0: if (en) m_phase = 1;
      1: begin m_taken = 0; m_phase = 2; end
      2: begin
        if (v && m_taken < N) begin
          if (CHK && a != m_taken) m_err = 1;
          else begin
            np = 1; m_paddr = m_taken; m_pdata = d; m_taken++;
          end
        end
        if (m_pend) begin
          m_commit++;
          if (m_commit == N) m_phase = 3;
        end
      end
      default: if (ii) begin m_commit = 0; m_phase = en ? 1 : 0; end
    endcase
    m_pend = np;
  endtask

  initial begin
    int na;
    logic [AW-1:0] s_addr[10];
    logic [DW-1:0] s_data[10];
    bit            s_wr[10];
    logic [AW-1:0] s_eaddr[10];

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #8;
    chk_all_zero("reset");
    drive(1, 0, 0, 0, 0);
    #14;
    rst = 1'b0;   // released at t=22, first active edge at t=25

    // directed table: arm, 9 back-to-back words, extra words, rearm
    vt[0] = '{1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0, 0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 0, 1'b0};
    for (int k = 0; k < N; k++)
      vt[2+k] = '{1'b1, 1'b1, 4'(k), 16'(16'h0100 + k), 1'b0,
                  1'b0, 1'b1, 4'(k), 16'(16'h0100 + k), k, 1'b0};
    vt[11] = '{1'b1, 1'b1, 4'd0, 16'hDEAD, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 9, 1'b0};
    vt[12] = '{1'b1, 1'b1, 4'd0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 9, CHK};
    vt[13] = '{1'b1, 1'b0, 4'd0, 16'h0,    1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 0, CHK};
    vt[14] = '{1'b1, 1'b0, 4'd0, 16'h0,    1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 0, CHK};

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].en, vt[i].v, vt[i].a, vt[i].d, vt[i].ii);
      step();
      chk($sformatf("vec%0d done", i), 32'(bus.acc_done_out), 32'(vt[i].e_done));
      chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(vt[i].e_wr));
      if (vt[i].e_wr) begin
        chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(vt[i].e_addr));
        chk($sformatf("vec%0d wr_data", i), 32'(wr_data), 32'(vt[i].e_data));
      end
      chk($sformatf("vec%0d idx", i), 32'(idx), 32'(vt[i].e_idx));
      chk($sformatf("vec%0d err", i), 32'(err_out), 32'(vt[i].e_err));
    end

    // out-of-order address word; fresh transfer from reset so err starts low
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    drive(1, 0, 0, 0, 0);
    step();
    chk("oo arm done", 32'(bus.acc_done_out), 1);
    step();
    chk("oo err before", 32'(err_out), 0);
`ifdef ACC_RECV_ADDR_CHK_EN
    na = 10;
    for (int k = 0; k < 10; k++) begin
      s_addr[k]  = (k < 3) ? 4'(k) : (k == 3) ? 4'd5 : 4'(k - 1);
      s_data[k]  = (k == 3) ? 16'h0BAD : 16'(16'h0100 + ((k < 3) ? k : k - 1));
      s_wr[k]    = (k != 3);
      s_eaddr[k] = (k < 3) ? 4'(k) : 4'(k - 1);
    end
`else
    na = 9;
    for (int k = 0; k < 9; k++) begin
      s_addr[k]  = (k == 3) ? 4'd5 : 4'(k);
      s_data[k]  = (k == 3) ? 16'h0BAD : 16'(16'h0100 + k);
      s_wr[k]    = 1'b1;
      s_eaddr[k] = 4'(k);
    end
`endif
    for (int k = 0; k < na; k++) begin
      drive(1, 1, s_addr[k], s_data[k], 0);
      step();
      chk($sformatf("oo%0d wr_en", k), 32'(wr_en), 32'(s_wr[k]));
      if (s_wr[k]) begin
        chk($sformatf("oo%0d wr_addr", k), 32'(wr_addr), 32'(s_eaddr[k]));
        chk($sformatf("oo%0d wr_data", k), 32'(wr_data), 32'(s_data[k]));
      end
      if (k >= 3) chk($sformatf("oo%0d err", k), 32'(err_out), 32'(CHK));
    end
    drive(1, 0, 0, 0, 0);
    step();
    chk("oo idx full", 32'(idx), 9);
    drive(1, 0, 0, 0, 1);
    step();
    chk("oo rearm done", 32'(bus.acc_done_out), 1);
    chk("oo rearm idx", 32'(idx), 0);

    // reset in the middle of a cycle after four words
    drive(1, 0, 0, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 4'(k), 16'(16'h0200 + k), 0);
      step();
    end
    chk("mid wr_en before rst", 32'(wr_en), 1);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    #2 rst = 1'b0;
    drive(1, 0, 0, 0, 0);
    step();
    chk("post rst done", 32'(bus.acc_done_out), 1);
    step();
    chk("post rst done low", 32'(bus.acc_done_out), 0);
    drive(1, 1, 4'd0, 16'h55AA, 0);
    step();
    chk("post rst wr_en", 32'(wr_en), 1);
    chk("post rst wr_addr", 32'(wr_addr), 0);
    chk("post rst wr_data", 32'(wr_data), 16'h55AA);
    drive(1, 0, 0, 0, 0);
    step();
    chk("post rst idx", 32'(idx), 1);

    // randomized run against the reference model
    #3 rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      bit          r_en, r_v, r_ii;
      logic [AW-1:0] r_a;
      logic [DW-1:0] r_d;
      r_en = ($urandom_range(0, 3) != 0);
      r_v  = ($urandom_range(0, 9) < 7);
      r_ii = ($urandom_range(0, 9) < 3);
      r_a  = ($urandom_range(0, 3) != 0) ? 4'(m_taken) : 4'($urandom_range(0, 15));
      r_d  = 16'($urandom);
      drive(r_en, r_v, r_a, r_d, r_ii);
      step();
      model_clock(r_en, r_v, int'(r_a), int'(r_d), r_ii);
      chk("rnd done", 32'(bus.acc_done_out), 32'(m_phase == 1));
      chk("rnd wr_en", 32'(wr_en), 32'(m_pend));
      if (m_pend) begin
        chk("rnd wr_addr", 32'(wr_addr), 32'(m_paddr));
        chk("rnd wr_data", 32'(wr_data), 32'(m_pdata));
      end
      chk("rnd idx", 32'(idx), 32'(m_commit));
      chk("rnd err", 32'(err_out), 32'(m_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_recv_ctrl.md
ACC_RECV_CTRL -- requirements
Module: acc_recv_ctrl

Interface
REQ-001 SHALL have parameter ACC_ADDR_W, default 4, accumulator address width.
REQ-002 SHALL have parameter ACC_SIZE, default 9, number of accumulator words per transfer.
REQ-003 SHALL have parameter DATA_W, default 16, accumulator word width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port en_in  input  1  level; this PE may accept a new transfer.
REQ-007 SHALL have port acc_valid_in  input  1  upstream address/data valid this cycle.
REQ-008 SHALL have port acc_addr_in  input  ACC_ADDR_W  upstream word address.
REQ-009 SHALL have port acc_data_in  input  DATA_W  upstream word data.
REQ-010 SHALL have port idx_init  input  1  local send part has drained the buffer; clears idx.
REQ-011 SHALL have port acc_done_out  output  1  one-cycle pulse; this PE is ready to receive.
REQ-012 SHALL have port wr_en  output  1  local accumulator write strobe.
REQ-013 SHALL have port wr_addr  output  ACC_ADDR_W  local accumulator write address.
REQ-014 SHALL have port wr_data  output  DATA_W  local accumulator write data.
REQ-015 SHALL have port idx  output  $clog2(ACC_SIZE+1)  count of committed words, 0..ACC_SIZE.
REQ-016 SHALL have port err_out  output  1  sticky sequence-error flag.

Function
REQ-017 SHALL implement FSM states IDLE, ARM, RECV, FULL.
REQ-018 IDLE: go to ARM when en_in=1; else stay.
REQ-019 ARM: assert acc_done_out for exactly this one cycle; go to RECV unconditionally.
REQ-020 RECV: acc_valid_in=1 is accepted; internal expected pointer ptr (0..ACC_SIZE-1) advances by 1 per accepted word.
REQ-021 Accepted word SHALL appear on wr_en/wr_addr/wr_data one cycle after sampling (registered); wr_addr = ptr at sampling time.
REQ-022 idx SHALL increment one cycle after each wr_en pulse, so idx counts only completed writes.
REQ-023 ptr SHALL wrap from ACC_SIZE-1 to 0 on the last accepted word; no further words are accepted in that transfer.
REQ-024 RECV -> FULL in the cycle idx becomes ACC_SIZE; words arriving after the last accept and before FULL are dropped.
REQ-025 FULL: hold idx=ACC_SIZE; on idx_init=1 clear idx to 0 and go to ARM if en_in=1, else IDLE.
REQ-026 idx_init in IDLE, ARM or RECV SHALL be ignored.
REQ-027 acc_valid_in in IDLE, ARM or FULL SHALL be dropped (no wr_en).
REQ-028 Back-to-back valid words SHALL be accepted one per cycle with no bubbles.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, ptr=0, idx=0, acc_done_out=0, wr_en=0, wr_addr=0, wr_data=0, err_out=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer; partially written words are not counted and no acc_done_out is issued until a new ARM.

Configuration
REQ-031 Macro ACC_RECV_ADDR_CHK_EN defined: in RECV, a word with acc_addr_in != ptr SHALL be dropped (no wr_en, ptr unchanged) and set err_out; valid in IDLE/ARM/FULL also sets err_out; err_out clears only on reset.
REQ-032 Macro ACC_RECV_ADDR_CHK_EN undefined: acc_addr_in SHALL be ignored, every RECV word is accepted at ptr, err_out tied 0.

Verification
REQ-033 Reset, en_in=1 -> acc_done_out pulse 1 cycle in cycle 2 after reset release, state RECV.
REQ-034 9 back-to-back words addr 0..8, data 0x0100..0x0108 -> 9 consecutive wr_en, wr_addr 0..8 matching data; idx 1..9 lagging wr_en by 1; FULL at idx=9.
REQ-035 In FULL, extra valid word, then idx_init=1 with en_in=1 -> extra word dropped, idx=0, new acc_done_out pulse next cycle.
REQ-036 With ACC_RECV_ADDR_CHK_EN: word 3 sent with addr 5 -> no wr_en, err_out=1 held, resend addr 3 accepted, transfer completes at idx=9.
REQ-037 Without macro: same stimulus as REQ-036 -> addr 5 word written at wr_addr 3, err_out stays 0.
REQ-038 rst=1 asserted after 4 words, mid-cycle -> all outputs zero immediately; after release with en_in=1, new transfer from ptr 0.
